// File: rtl/sub_operand_loader_if.sv
// Operand-loader bus: upstream beat handshake, flush, and pair output handshake.
interface sub_operand_loader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       pair_cnt;
    logic             busy;

    // Upstream/downstream side that feeds beats and consumes pairs.
    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, a_out, b_out, out_valid, pair_cnt, busy
    );

    // The loader itself.
    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, a_out, b_out, out_valid, pair_cnt, busy
    );
endinterface

// File: rtl/sub_operand_loader.sv
// Collects two operand beats (minuend, then subtrahend) and presents them as
// a pair to the subtractor stage; counts delivered pairs modulo 256.
//
// state | meaning
// S_A   | await minuend beat
// S_B   | await subtrahend beat
// S_OUT | present pair, wait for out_ready
module sub_operand_loader #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sub_operand_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             in_ready;
    logic             accept;

    // Ready depends on registered state only, so no input reaches an output.
    assign in_ready = (state_q == S_A) || (state_q == S_B);
    assign accept   = bus.in_valid && in_ready;

    // Next-state and datapath; flush overrides both beat accept and pair handshake.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (accept) begin
                        a_d     = bus.in_data;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (accept) begin
                        b_d     = bus.in_data;
                        state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = S_A;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    // State and operand registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.pair_cnt  = cnt_q;
    assign bus.busy      = (state_q != S_A);

endmodule

// File: tb/tb_sub_operand_loader.sv
// Directed bench for sub_operand_loader: pair capture, backpressure, flush,
// async reset, and pair counter wrap.
module tb_sub_operand_loader;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sub_operand_loader_if #(.WIDTH(WIDTH)) bus ();

    sub_operand_loader #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int ov, input int a, input int b, input int cnt);
        chk({tag, " out_valid"}, 32'(bus.out_valid), ov);
        chk({tag, " a_out"},     32'(bus.a_out),     a);
        chk({tag, " b_out"},     32'(bus.b_out),     b);
        chk({tag, " pair_cnt"},  32'(bus.pair_cnt),  cnt);
        chk({tag, " in_ready"},  32'(bus.in_ready),  ov ? 0 : 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state, before any clock edge.
        #3;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset busy", 32'(bus.busy), 0);
        #4 rst_n = 1'b1;
        step();

        // Pair 0x9/0x3 with out_ready held high.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h9;
        step();
        chk("t1 busy in S_B", 32'(bus.busy), 1);
        chk_out("t1 S_B", 0, 9, 0, 0);
        bus.in_data = 4'h3;
        step();
        chk_out("t1 S_OUT", 1, 9, 3, 0);
        bus.in_valid = 1'b0;
        step();
        chk_out("t1 handshake", 0, 9, 3, 1);
        chk("t1 busy idle", 32'(bus.busy), 0);

        // Pair 0xF/0x1 held under backpressure while 0x7 is offered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'hF;
        step();
        bus.in_data = 4'h1;
        step();
        bus.in_data = 4'h7;
        for (int i = 0; i < 5; i++) begin
            chk_out("t2 hold", 1, 15, 1, 1);
            step();
        end
        chk_out("t2 hold end", 1, 15, 1, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk_out("t2 release", 0, 15, 1, 2);
        step();
        chk("t2 single count", 32'(bus.pair_cnt), 2);

        // Flush in S_B after minuend 0x5.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h5;
        step();
        chk("t3 a captured", 32'(bus.a_out), 5);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t3 busy after flush", 32'(bus.busy), 0);
        chk_out("t3 flushed", 0, 0, 0, 2);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h2;
        step();
        step();
        chk_out("t3 pair 2/2", 1, 2, 2, 2);
        bus.in_valid = 1'b0;
        step();
        chk_out("t3 delivered", 0, 2, 2, 3);

        // Flush coinciding with an accepted beat in S_A drops the beat.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h6;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("t3b busy", 32'(bus.busy), 0);
        chk("t3b a dropped", 32'(bus.a_out), 0);

        // Flush together with out_ready in S_OUT discards the pair uncounted.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h4;
        step();
        bus.in_data = 4'h8;
        step();
        bus.in_valid = 1'b0;
        chk_out("t4 pending", 1, 4, 8, 3);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.flush = 1'b0;
        chk_out("t4 flush+ready", 0, 0, 0, 3);

        // Asynchronous reset mid-cycle in S_OUT.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'hA;
        step();
        bus.in_data = 4'hB;
        step();
        bus.in_valid = 1'b0;
        chk_out("t6 pending", 1, 10, 11, 3);
        #2 rst_n = 1'b0;
        #1;
        chk_out("t6 async reset", 0, 0, 0, 0);
        chk("t6 busy", 32'(bus.busy), 0);
        #2 rst_n = 1'b1;
        step();
        chk_out("t6 after reset", 0, 0, 0, 0);

        // 256 back-to-back pairs wrap the counter to 0; one more gives 1.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 257; i++) begin
            bus.in_data = 4'(i);
            step();
            bus.in_data = 4'(~i);
            step();
            chk_out("t5 pair", 1, i & 15, (~i) & 15, i & 255);
            step();
            if (i == 254) chk("t5 cnt 255", 32'(bus.pair_cnt), 255);
            if (i == 255) chk("t5 cnt wrap", 32'(bus.pair_cnt), 0);
        end
        bus.in_valid = 1'b0;
        chk("t5 cnt 257th", 32'(bus.pair_cnt), 1);
        chk("t5 idle", 32'(bus.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
